// File: rtl/pipe_pkg.sv
// Shared types and sizing helpers for the elastic pipeline register.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_FULL  = 2'd2
    } ps_state_t;

    // Width needed to count every main and skid entry, including the all-full value.
    function automatic int pipe_cnt_w(input int depth, input int skid);
        return $clog2(depth * (skid + 1) + 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// Single elastic stage: plain valid/data flop (SKID=0) or main+skid pair (SKID=1).
// Latency: one cycle from accept to out_valid in both modes.
// Backpressure: SKID=0 ready is combinational from out_ready; SKID=1 ready is registered.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SKID  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    if (SKID == 0) begin : g_plain
        logic             vld_q;
        logic [WIDTH-1:0] dat_q;

        // An empty stage loads even under stall, so bubbles collapse toward the head.
        assign in_ready  = !vld_q || out_ready;
        assign out_valid = vld_q;
        assign out_data  = dat_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                vld_q <= 1'b0;
                dat_q <= '0;
            end else if (flush) begin
                vld_q <= 1'b0;
            end else if (in_ready) begin
                vld_q <= in_valid;
                if (in_valid) begin
                    dat_q <= in_data;
                end
            end
        end
    end else begin : g_skid
        ps_state_t        state_q, state_nxt;
        logic             rdy_q;
        logic [WIDTH-1:0] main_q, main_nxt;
        logic [WIDTH-1:0] skid_q, skid_nxt;
        logic             accept, send;

        assign accept    = in_valid && rdy_q;
        assign send      = (state_q != PS_EMPTY) && out_ready;
        assign in_ready  = rdy_q;
        assign out_valid = (state_q != PS_EMPTY);
        assign out_data  = main_q;

        always_comb begin
            state_nxt = state_q;
            main_nxt  = main_q;
            skid_nxt  = skid_q;
            case (state_q)
                PS_EMPTY: begin
                    if (accept) begin
                        state_nxt = PS_ONE;
                        main_nxt  = in_data;
                    end
                end
                PS_ONE: begin
                    if (accept && send) begin
                        main_nxt = in_data;
                    end else if (accept) begin
                        state_nxt = PS_FULL;
                        skid_nxt  = in_data;
                    end else if (send) begin
                        state_nxt = PS_EMPTY;
                    end
                end
                PS_FULL: begin
                    // Ready is low in FULL, so the skid entry drains before any new beat.
                    if (send) begin
                        state_nxt = PS_ONE;
                        main_nxt  = skid_q;
                    end
                end
                default: state_nxt = PS_EMPTY;
            endcase
            if (flush) begin
                state_nxt = PS_EMPTY;
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= PS_EMPTY;
                rdy_q   <= 1'b1;
                main_q  <= '0;
                skid_q  <= '0;
            end else begin
                state_q <= state_nxt;
                rdy_q   <= (state_nxt != PS_FULL);
                main_q  <= main_nxt;
                skid_q  <= skid_nxt;
            end
        end
    end

endmodule

// File: rtl/pipe_reg.sv
// Elastic pipeline register: DEPTH chained stages with flush and occupancy count.
// Latency: DEPTH cycles accept-to-out_valid; 1 beat/cycle sustained.
// Backpressure: holds DEPTH (SKID=0) or 2*DEPTH (SKID=1) beats; in_ready low during flush.
module pipe_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1,
    parameter int SKID  = 0,
    parameter int CNT_W = pipe_cnt_w(DEPTH, SKID)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] occupancy
);

    // Per-stage handshake nets live in each generate block so the ready chain
    // is a set of distinct nets rather than one self-referencing vector.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_vld, up_rdy, dn_vld, dn_rdy;
        logic [WIDTH-1:0] up_dat, dn_dat;

        if (i == 0) begin : g_head
            assign up_vld = in_valid && !flush;
            assign up_dat = in_data;
        end else begin : g_link
            assign up_vld = g_stage[i-1].dn_vld;
            assign up_dat = g_stage[i-1].dn_dat;
        end

        if (i == DEPTH - 1) begin : g_tail
            assign dn_rdy = out_ready;
        end else begin : g_next
            assign dn_rdy = g_stage[i+1].up_rdy;
        end

        pipe_stage #(
            .WIDTH (WIDTH),
            .SKID  (SKID)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .in_valid  (up_vld),
            .in_data   (up_dat),
            .in_ready  (up_rdy),
            .out_valid (dn_vld),
            .out_data  (dn_dat),
            .out_ready (dn_rdy)
        );
    end

    assign in_ready  = g_stage[0].up_rdy && !flush;
    assign out_valid = g_stage[DEPTH-1].dn_vld;
    assign out_data  = g_stage[DEPTH-1].dn_dat;

    logic acc, snd;
    assign acc = in_valid && in_ready;
    assign snd = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else if (acc && !snd) begin
            occupancy <= occupancy + 1'b1;
        end else if (snd && !acc) begin
            occupancy <= occupancy - 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_reg.sv
// Directed bench for pipe_reg across three configurations sharing one clock and reset.
module tb_pipe_reg;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // u0: DEPTH=4 SKID=0
    logic       a_flush, a_iv, a_ir, a_ov, a_or;
    logic [7:0] a_id, a_od;
    logic [2:0] a_occ;
    // u1: DEPTH=3 SKID=0
    logic       b_flush, b_iv, b_ir, b_ov, b_or;
    logic [7:0] b_id, b_od;
    logic [1:0] b_occ;
    // u2: DEPTH=2 SKID=1
    logic       c_flush, c_iv, c_ir, c_ov, c_or;
    logic [7:0] c_id, c_od;
    logic [2:0] c_occ;

    int total  = 0;
    int passed = 0;

    pipe_reg #(.WIDTH(8), .DEPTH(4), .SKID(0)) u0 (
        .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_iv), .in_data(a_id), .in_ready(a_ir),
        .out_valid(a_ov), .out_data(a_od), .out_ready(a_or), .occupancy(a_occ));

    pipe_reg #(.WIDTH(8), .DEPTH(3), .SKID(0)) u1 (
        .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_iv), .in_data(b_id), .in_ready(b_ir),
        .out_valid(b_ov), .out_data(b_od), .out_ready(b_or), .occupancy(b_occ));

    pipe_reg #(.WIDTH(8), .DEPTH(2), .SKID(1)) u2 (
        .clk(clk), .rst(rst), .flush(c_flush), .in_valid(c_iv), .in_data(c_id), .in_ready(c_ir),
        .out_valid(c_ov), .out_data(c_od), .out_ready(c_or), .occupancy(c_occ));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic exp_v;
        step();
        step();
        total++; if (a_ov !== 1'b0)    $display("FAIL rst_out_valid: got %0h expected 0", a_ov);  else passed++;
        total++; if (a_od !== 8'h00)   $display("FAIL rst_out_data: got %0h expected 0", a_od);   else passed++;
        total++; if (a_occ !== 3'd0)   $display("FAIL rst_occ: got %0d expected 0", a_occ);       else passed++;
        total++; if (a_ir !== 1'b1)    $display("FAIL rst_in_ready_s0: got %0h expected 1", a_ir); else passed++;
        total++; if (c_ir !== 1'b1)    $display("FAIL rst_in_ready_s1: got %0h expected 1", c_ir); else passed++;
        total++; if (c_ov !== 1'b0)    $display("FAIL rst_out_valid_s1: got %0h expected 0", c_ov); else passed++;
        rst = 1'b1;
        a_or = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a_iv = 1'b1;
            a_id = 8'(17 * (k + 1));
            step();
        end
        a_iv = 1'b0;
        step();
        total++; if (a_occ !== 3'd3)   $display("FAIL pre_rst_occ: got %0d expected 3", a_occ);   else passed++;
        total++; if (a_ov !== 1'b1)    $display("FAIL pre_rst_valid: got %0h expected 1", a_ov);  else passed++;
        total++; if (a_od !== 8'h11)   $display("FAIL pre_rst_data: got %0h expected 11", a_od);  else passed++;
        // Asynchronous assertion mid-cycle, checked before the next edge.
        #2 rst = 1'b0;
        #1;
        total++; if (a_ov !== 1'b0)    $display("FAIL async_rst_valid: got %0h expected 0", a_ov); else passed++;
        total++; if (a_od !== 8'h00)   $display("FAIL async_rst_data: got %0h expected 0", a_od);  else passed++;
        total++; if (a_occ !== 3'd0)   $display("FAIL async_rst_occ: got %0d expected 0", a_occ);  else passed++;
        #1 rst = 1'b1;
        a_iv = 1'b1;
        a_id = 8'hA5;
        a_or = 1'b1;
        step();
        a_iv = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) step();
            exp_v = (c == 4);
            total++; if (a_ov !== exp_v) $display("FAIL latency_valid_c%0d: got %0h expected %0h", c, a_ov, exp_v); else passed++;
        end
        total++; if (a_od !== 8'hA5)   $display("FAIL latency_data: got %0h expected a5", a_od);  else passed++;
        step();
        total++; if (a_occ !== 3'd0)   $display("FAIL post_send_occ: got %0d expected 0", a_occ); else passed++;
    endtask

    task automatic test_streaming();
        logic exp_v;
        int   eo;
        b_or = 1'b1;
        for (int c = 0; c < 14; c++) begin
            b_iv = (c < 10);
            b_id = 8'(c + 1);
            #1;
            exp_v = (c >= 3 && c <= 12);
            eo = ((c < 10) ? c : 10) - ((c > 3) ? c - 3 : 0);
            total++; if (b_ov !== exp_v) $display("FAIL stream_valid_c%0d: got %0h expected %0h", c, b_ov, exp_v); else passed++;
            if (exp_v) begin
                total++; if (b_od !== 8'(c - 2)) $display("FAIL stream_data_c%0d: got %0d expected %0d", c, b_od, c - 2); else passed++;
            end
            total++; if (b_occ !== 2'(eo)) $display("FAIL stream_occ_c%0d: got %0d expected %0d", c, b_occ, eo); else passed++;
            if (c < 10) begin
                total++; if (b_ir !== 1'b1) $display("FAIL stream_ready_c%0d: got %0h expected 1", c, b_ir); else passed++;
            end
            step();
        end
        b_iv = 1'b0;
    endtask

    task automatic test_backpressure();
        int   next;
        int   got;
        logic exp_r;
        next = 0;
        c_or = 1'b0;
        for (int c = 0; c < 6; c++) begin
            c_iv = 1'b1;
            c_id = 8'(8'h61 + next);
            #1;
            exp_r = (c < 4);
            total++; if (c_ir !== exp_r) $display("FAIL bp_ready_c%0d: got %0h expected %0h", c, c_ir, exp_r); else passed++;
            if (c_ir) next++;
            step();
        end
        c_iv = 1'b0;
        total++; if (next != 4)         $display("FAIL bp_accepted: got %0d expected 4", next);     else passed++;
        total++; if (c_occ !== 3'd4)    $display("FAIL bp_occ: got %0d expected 4", c_occ);         else passed++;
        total++; if (c_ov !== 1'b1)     $display("FAIL bp_head_valid: got %0h expected 1", c_ov);   else passed++;
        total++; if (c_od !== 8'h61)    $display("FAIL bp_head_data: got %0h expected 61", c_od);   else passed++;
        got = 0;
        c_or = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c_ov) begin
                total++; if (c_od !== 8'(8'h61 + got)) $display("FAIL bp_drain_%0d: got %0h expected %0h", got, c_od, 8'h61 + got); else passed++;
                got++;
            end
            step();
        end
        total++; if (got != 4)          $display("FAIL bp_drain_count: got %0d expected 4", got);   else passed++;
        total++; if (c_occ !== 3'd0)    $display("FAIL bp_drain_occ: got %0d expected 0", c_occ);   else passed++;
        total++; if (c_ir !== 1'b1)     $display("FAIL bp_ready_after: got %0h expected 1", c_ir);  else passed++;
    endtask

    task automatic test_bubble();
        a_or = 1'b0;
        a_iv = 1'b1;
        a_id = 8'h5A;
        step();
        a_iv = 1'b0;
        step();
        step();
        step();
        total++; if (a_ov !== 1'b1)     $display("FAIL bubble_head_valid: got %0h expected 1", a_ov); else passed++;
        total++; if (a_od !== 8'h5A)    $display("FAIL bubble_head_data: got %0h expected 5a", a_od); else passed++;
        total++; if (a_occ !== 3'd1)    $display("FAIL bubble_occ1: got %0d expected 1", a_occ);      else passed++;
        a_iv = 1'b1;
        a_id = 8'h5B;
        #1;
        total++; if (a_ir !== 1'b1)     $display("FAIL bubble_ready_stalled: got %0h expected 1", a_ir); else passed++;
        step();
        a_iv = 1'b0;
        total++; if (a_occ !== 3'd2)    $display("FAIL bubble_occ2: got %0d expected 2", a_occ);      else passed++;
        total++; if (a_od !== 8'h5A)    $display("FAIL bubble_head_kept: got %0h expected 5a", a_od); else passed++;
    endtask

    task automatic test_flush();
        a_iv = 1'b1;
        a_id = 8'h5C;
        step();
        a_iv = 1'b0;
        total++; if (a_occ !== 3'd3)    $display("FAIL flush_pre_occ: got %0d expected 3", a_occ);    else passed++;
        a_flush = 1'b1;
        a_iv = 1'b1;
        a_id = 8'h5D;
        a_or = 1'b1;
        #1;
        total++; if (a_ir !== 1'b0)     $display("FAIL flush_in_ready: got %0h expected 0", a_ir);    else passed++;
        total++; if (a_ov !== 1'b1)     $display("FAIL flush_out_unmasked: got %0h expected 1", a_ov); else passed++;
        total++; if (a_od !== 8'h5A)    $display("FAIL flush_delivered: got %0h expected 5a", a_od);  else passed++;
        step();
        a_flush = 1'b0;
        a_iv = 1'b0;
        a_or = 1'b0;
        #1;
        total++; if (a_occ !== 3'd0)    $display("FAIL flush_occ: got %0d expected 0", a_occ);        else passed++;
        total++; if (a_ov !== 1'b0)     $display("FAIL flush_out_valid: got %0h expected 0", a_ov);   else passed++;
        total++; if (a_ir !== 1'b1)     $display("FAIL flush_ready_after: got %0h expected 1", a_ir); else passed++;
        step();
    endtask

    task automatic test_simultaneous();
        logic [7:0] sb[$];
        logic [7:0] exp_d;
        int         delivered;
        delivered = 0;
        a_or = 1'b0;
        for (int k = 0; k < 4; k++) begin
            a_iv = 1'b1;
            a_id = 8'(8'h71 + k);
            #1;
            total++; if (a_ir !== 1'b1) $display("FAIL sim_fill_ready_%0d: got %0h expected 1", k, a_ir); else passed++;
            if (a_ir) sb.push_back(a_id);
            step();
        end
        a_id = 8'h75;
        #1;
        total++; if (a_ir !== 1'b0)     $display("FAIL sim_full_ready: got %0h expected 0", a_ir);    else passed++;
        total++; if (a_occ !== 3'd4)    $display("FAIL sim_full_occ: got %0d expected 4", a_occ);     else passed++;
        a_or = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a_iv = 1'b1;
            a_id = 8'(8'h75 + k);
            #1;
            total++; if (a_occ !== 3'd4) $display("FAIL sim_occ_%0d: got %0d expected 4", k, a_occ); else passed++;
            total++; if (a_ir !== 1'b1)  $display("FAIL sim_ready_%0d: got %0h expected 1", k, a_ir); else passed++;
            if (a_ir) sb.push_back(a_id);
            if (a_ov) begin
                exp_d = (sb.size() > 0) ? sb.pop_front() : 8'hXX;
                total++; if (a_od !== exp_d) $display("FAIL sim_order_%0d: got %0h expected %0h", delivered, a_od, exp_d); else passed++;
                delivered++;
            end
            step();
        end
        a_iv = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (a_ov) begin
                exp_d = (sb.size() > 0) ? sb.pop_front() : 8'hXX;
                total++; if (a_od !== exp_d) $display("FAIL sim_order_%0d: got %0h expected %0h", delivered, a_od, exp_d); else passed++;
                delivered++;
            end
            step();
        end
        total++; if (delivered != 8)    $display("FAIL sim_delivered: got %0d expected 8", delivered); else passed++;
        total++; if (sb.size() != 0)    $display("FAIL sim_leftover: got %0d expected 0", sb.size());  else passed++;
        total++; if (a_occ !== 3'd0)    $display("FAIL sim_final_occ: got %0d expected 0", a_occ);     else passed++;
    endtask

    initial begin
        a_flush = 1'b0; a_iv = 1'b0; a_id = 8'h00; a_or = 1'b0;
        b_flush = 1'b0; b_iv = 1'b0; b_id = 8'h00; b_or = 1'b0;
        c_flush = 1'b0; c_iv = 1'b0; c_id = 8'h00; c_or = 1'b0;
        rst = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_bubble();
        test_flush();
        test_simultaneous();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipe_reg.md
# pipe_reg

Parametrised elastic pipeline register: a chain of `DEPTH` register stages carrying a `WIDTH`-bit payload under a valid/ready handshake. It supports a synchronous flush and an optional skid mode that registers the ready path. It replaces plain per-stage flops between OOO core stages, such as fetch→decode and rename→dispatch, where backpressure and mispredict flushes must be honoured.

## Interface
- `WIDTH`, 32: payload width in bits (≥1).
- `DEPTH`, 1: number of register stages (≥1).
- `SKID`, 0: 0 = plain stages with a combinational ready chain; 1 = each stage is a 2-entry skid buffer and `in_ready` is a register output.
- `CNT_W`, `$clog2(DEPTH*(SKID+1)+1)`: occupancy counter width (derived; do not override).

Ports:
- `clk`  input  1  rising-edge clock; the only clock.
- `rst`  input  1  reset; asynchronous, active-low.
- `flush`  input  1  synchronous flush; drops all held and incoming beats.
- `in_valid`  input  1  upstream beat valid.
- `in_data`  input  WIDTH  upstream payload.
- `in_ready`  output  1  block accepts a beat this cycle.
- `out_valid`  output  1  head beat valid.
- `out_data`  output  WIDTH  head payload.
- `out_ready`  input  1  downstream accepts the head beat.
- `occupancy`  output  CNT_W  number of valid entries held.

## Operation
- Beat transfers occur at the rising edge when `valid && ready` on that side.
- Payload order is preserved. There is no duplication and no loss, except on flush.
- **SKID=0 stage `i`:**
  - `ready_i = !valid_q[i] || ready_{i+1}`, with `ready_DEPTH = out_ready`.
  - Bubbles collapse: an empty stage loads even when downstream is stalled.
  - `in_ready = ready_0` and is combinational from `out_ready`.
- **SKID=1 stage:**
  - Holds a main and a skid entry. Its ready output is `!skid_valid_q`, registered.
  - A beat arriving while the stage is stalled lands in the skid entry.
  - The skid entry drains into main before new input is taken.
  - The stage has three states: EMPTY (0 entries), ONE (main valid), FULL (main + skid). Transitions:
    - EMPTY→ONE on accept.
    - ONE→FULL on accept with downstream stall.
    - ONE→EMPTY on send with no accept.
    - FULL→ONE on send.
    - ONE→ONE on simultaneous accept and send.
- **Flush:** while `flush`=1, `in_ready`=0. At the next edge every valid bit clears and `occupancy`→0.
  - `out_valid` is not masked during the flush cycle. An output handshake in that cycle still completes.
- **occupancy:** the count of set valid bits, both main and skid. It is registered and updated each edge: +1 on input accept, −1 on output send, unchanged if both or neither.
- **Reset:** asserting `rst` low immediately clears all valid bits, all data registers (to 0), and occupancy.
  - During and after reset: `out_valid`=0, `out_data`=0, `occupancy`=0.
  - `in_ready` is 1 for SKID=0 and 1 for SKID=1.

## Timing
- Latency, input accept to `out_valid`, with no stall: DEPTH cycles in both modes.
- Throughput: 1 beat/cycle sustained while `out_ready`=1.
- Capacity when stalled: DEPTH beats (SKID=0) or 2·DEPTH beats (SKID=1).
  - After that, `in_ready`=0 in the same cycle (SKID=0) or one cycle after the last skid fill (SKID=1).
- SKID=0: there is a combinational path `out_ready`→`in_ready` through DEPTH gates.
- SKID=1: there is no combinational input→output path.
- Reset release is synchronised externally. The block samples `rst` high at the first edge after deassertion.
- Simultaneous `flush` and `rst` low: reset wins.

## Structure
- Shared package `pipe_pkg`: the skid-stage state enum (`PS_EMPTY`, `PS_ONE`, `PS_FULL`) and a `pipe_cnt_w(depth, skid)` function.
- Sub-module `pipe_stage` (WIDTH, SKID): a single stage with in/out valid/ready, data, and flush.
- `pipe_reg` instantiates DEPTH copies of `pipe_stage` via generate and owns the occupancy counter.

## Test plan
- **Reset:** hold `rst`=0 mid-stream with 3 beats inside (DEPTH=4) → `out_valid`=0, `out_data`=0, `occupancy`=0 asynchronously. After release, the first beat `0xA5` emerges 4 cycles after accept.
- **Streaming:** DEPTH=3, SKID=0, `out_ready`=1, inputs 1..10 back-to-back → outputs 1..10, the first at cycle 3, with no gaps and `occupancy` steady at 3.
- **Backpressure:** DEPTH=2, SKID=1, `out_ready`=0, 6 beats offered → 4 accepted, `in_ready` falls after the 4th, `occupancy`=4. Releasing `out_ready` drains in order.
- **Bubble collapse:** DEPTH=4, SKID=0, a single beat followed by a stall → the beat reaches the head. A second beat is accepted while the head is stalled, and `occupancy`=2.
- **Flush:** `flush` pulses with 3 beats held and `in_valid`=1 → `in_ready`=0 that cycle, next cycle `occupancy`=0 and `out_valid`=0. The flush-cycle output handshake counts as delivered.
- **Simultaneous events:** accept and send in the same cycle at full occupancy (SKID=0) → `occupancy` unchanged, no lost or duplicated beat (scoreboard check).
